if_id_queue: RTL and testbench

//  Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry

---
 rtl/if_id_queue_pkg.sv | 21 ++
 rtl/if_id_queue_if.sv | 24 ++
 rtl/if_id_queue_ram.sv | 25 ++
 rtl/if_id_queue.sv | 115 +++++++++++
 tb/tb_if_id_queue.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue: default NOP, count-width helper
// and the {instr, npc} entry layout used by fetch, the queue and decode.
package if_queue_pkg;

    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned PC_W_DEF    = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    `define IF_QUEUE_ENTRY_W(iw, pw) ((iw) + (pw))

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [PC_W_DEF-1:0]    npc;
    } if_entry_t;

    // Occupancy must represent 0..DEPTH inclusive, hence DEPTH+1.
    function automatic int unsigned CNT_W(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side push and decode-side pop handshake bundle for the IF/ID queue.
interface if_id_queue_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned PC_W    = 32
);
    logic               push_valid;
    logic               push_ready;
    logic [INSTR_W-1:0] Instruction_F;
    logic [PC_W-1:0]    NPC_F;
    logic               pop_valid;
    logic               pop_ready;
    logic [INSTR_W-1:0] Instruction_D;
    logic [PC_W-1:0]    NPC_D;

    modport slave (
        input  push_valid, Instruction_F, NPC_F, pop_ready,
        output push_ready, pop_valid, Instruction_D, NPC_D
    );

    modport master (
        output push_valid, Instruction_F, NPC_F, pop_ready,
        input  push_ready, pop_valid, Instruction_D, NPC_D
    );
endinterface

// File: rtl/if_id_queue_ram.sv
// Entry storage for the IF/ID queue: one synchronous write port, one asynchronous read.
module if_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry circular queue between fetch and decode with kill flush, NOP on empty
// and an optional same-cycle bypass when empty.
module if_id_queue
    import if_queue_pkg::*;
#(
    parameter int unsigned        INSTR_W   = INSTR_W_DEF,
    parameter int unsigned        PC_W      = PC_W_DEF,
    parameter int unsigned        DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter bit                 PASSTHRU  = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        kill,
    if_id_queue_if.slave                q,
    output logic [CNT_W(DEPTH)-1:0]     count,
    output logic                        overflow_err
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CW      = CNT_W(DEPTH);
    localparam int unsigned ENTRY_W = `IF_QUEUE_ENTRY_W(INSTR_W, PC_W);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               empty, full, bypass;
    logic               push, pop_store, wr_en;
    logic [ENTRY_W-1:0] rd_data;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_npc;

    if_queue_ram #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({q.Instruction_F, q.NPC_F}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign head_instr = rd_data[ENTRY_W-1:PC_W];
    assign head_npc   = rd_data[PC_W-1:0];

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        bypass    = PASSTHRU && empty && q.push_valid && !kill;
        push      = q.push_valid && !full;
        pop_store = !empty && q.pop_ready;
        // A bypassed entry that decode takes immediately is never stored.
        wr_en     = push && !kill && !(bypass && q.pop_ready);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q || (q.push_valid && full);
        if (kill) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_store) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_en && !pop_store) begin
                count_d = count_q + 1'b1;
            end else if (!wr_en && pop_store) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        q.push_ready  = !full;
        q.pop_valid   = !empty || bypass;
        q.Instruction_D = NOP_INSTR;
        q.NPC_D         = '0;
        if (!empty) begin
            q.Instruction_D = head_instr;
            q.NPC_D         = head_npc;
        end else if (bypass) begin
            q.Instruction_D = q.Instruction_F;
            q.NPC_D         = q.NPC_F;
        end
    end

    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed scoreboard bench for if_id_queue: registered mode (dut0) and bypass mode (dut1).
module tb_if_id_queue;

    logic       clk;
    logic       reset;
    logic       kill0;
    logic       kill1;
    logic [2:0] count0, count1;
    logic       ovf0, ovf1;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];

    if_id_queue_if #(.INSTR_W(32), .PC_W(32)) q0 ();
    if_id_queue_if #(.INSTR_W(32), .PC_W(32)) q1 ();

    if_id_queue #(
        .INSTR_W(32), .PC_W(32), .DEPTH(4), .NOP_INSTR(32'h0), .PASSTHRU(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .kill(kill0), .q(q0),
        .count(count0), .overflow_err(ovf0)
    );

    if_id_queue #(
        .INSTR_W(32), .PC_W(32), .DEPTH(4), .NOP_INSTR(32'h0), .PASSTHRU(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .kill(kill1), .q(q1),
        .count(count1), .overflow_err(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already driven; samples mid-cycle, then advances.
    task automatic cyc();
        int         n;
        logic [63:0] e;
        #3;
        n = sb.size();
        chk("pop_valid", q0.pop_valid, (n != 0));
        chk("push_ready", q0.push_ready, (n != 4));
        chk("count", count0, n);
        if (kill0) begin
            sb.delete();
        end else begin
            if (q0.pop_ready && n > 0) begin
                e = sb.pop_front();
                chk("pop_head", {q0.Instruction_D, q0.NPC_D}, e);
            end
            if (q0.push_valid && n < 4) begin
                sb.push_back({q0.Instruction_F, q0.NPC_F});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle0();
        q0.push_valid = 1'b0;
        q0.pop_ready  = 1'b0;
        kill0         = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        kill0 = 1'b0;
        kill1 = 1'b0;
        q0.push_valid = 1'b0; q0.pop_ready = 1'b0;
        q0.Instruction_F = '0; q0.NPC_F = '0;
        q1.push_valid = 1'b0; q1.pop_ready = 1'b0;
        q1.Instruction_F = '0; q1.NPC_F = '0;

        #1;
        chk("rst_count", count0, 0);
        chk("rst_pop_valid", q0.pop_valid, 0);
        chk("rst_push_ready", q0.push_ready, 1);
        chk("rst_instr", q0.Instruction_D, 32'h0);
        chk("rst_npc", q0.NPC_D, 32'h0);
        chk("rst_ovf", ovf0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Fill with decode stalled
        q0.pop_ready = 1'b0;
        q0.push_valid = 1'b1;
        q0.Instruction_F = 32'hAAAAAAAA; q0.NPC_F = 32'd1; cyc();
        q0.Instruction_F = 32'hBBBBBBBB; q0.NPC_F = 32'd2; cyc();
        q0.Instruction_F = 32'hCCCCCCCC; q0.NPC_F = 32'd3; cyc();
        q0.Instruction_F = 32'hDDDDDDDD; q0.NPC_F = 32'd4; cyc();
        q0.push_valid = 1'b0;
        #3;
        chk("full_count", count0, 4);
        chk("full_push_ready", q0.push_ready, 0);
        chk("full_head", q0.Instruction_D, 32'hAAAAAAAA);
        chk("ovf_before", ovf0, 0);
        @(posedge clk);
        #1;

        // Overflow attempt
        q0.push_valid = 1'b1;
        q0.Instruction_F = 32'hEEEEEEEE; q0.NPC_F = 32'd5; cyc();
        q0.push_valid = 1'b0;
        #3;
        chk("ovf_count", count0, 4);
        chk("ovf_sticky", ovf0, 1);
        chk("stall_head", {q0.Instruction_D, q0.NPC_D}, {32'hAAAAAAAA, 32'd1});
        @(posedge clk);
        #1;

        // Drain in order
        q0.pop_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() > 0; i++) cyc();
        q0.pop_ready = 1'b0;
        #3;
        chk("drain_sb_empty", count0, sb.size());
        chk("drain_nop_instr", q0.Instruction_D, 32'h0);
        chk("drain_nop_npc", q0.NPC_D, 32'h0);
        chk("drain_pop_valid", q0.pop_valid, 0);
        chk("ovf_still", ovf0, 1);
        @(posedge clk);
        #1;

        // Kill with concurrent push and pop
        q0.push_valid = 1'b1;
        q0.Instruction_F = 32'h11111111; q0.NPC_F = 32'd11; cyc();
        q0.Instruction_F = 32'h22222222; q0.NPC_F = 32'd12; cyc();
        kill0 = 1'b1;
        q0.pop_ready = 1'b1;
        q0.Instruction_F = 32'hFFFFFFFF; q0.NPC_F = 32'd13; cyc();
        idle0();
        #3;
        chk("kill_count", count0, 0);
        chk("kill_instr", q0.Instruction_D, 32'h0);
        chk("kill_npc", q0.NPC_D, 32'h0);
        chk("kill_pop_valid", q0.pop_valid, 0);
        @(posedge clk);
        #1;
        q0.pop_ready = 1'b1;
        cyc();
        q0.pop_ready = 1'b0;

        // Wrap: one pre-push then ten concurrent push/pop cycles
        q0.push_valid = 1'b1;
        q0.Instruction_F = 32'h30000000; q0.NPC_F = 32'd0; cyc();
        q0.pop_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            q0.Instruction_F = 32'h30000000 + i;
            q0.NPC_F = i;
            cyc();
        end
        q0.push_valid = 1'b0;
        cyc();
        idle0();
        #3;
        chk("wrap_end_count", count0, 0);
        chk("wrap_sb_left", sb.size(), 0);
        @(posedge clk);
        #1;

        // Mid-run asynchronous reset with three entries held
        q0.push_valid = 1'b1;
        q0.Instruction_F = 32'h40000001; q0.NPC_F = 32'd21; cyc();
        q0.Instruction_F = 32'h40000002; q0.NPC_F = 32'd22; cyc();
        q0.Instruction_F = 32'h40000003; q0.NPC_F = 32'd23; cyc();
        q0.push_valid = 1'b0;
        chk("pre_rst_count", count0, 3);
        reset = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_count", count0, 0);
        chk("mid_rst_pop_valid", q0.pop_valid, 0);
        chk("mid_rst_push_ready", q0.push_ready, 1);
        chk("mid_rst_instr", q0.Instruction_D, 32'h0);
        chk("mid_rst_ovf", ovf0, 0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Bypass instance: consumed same cycle
        q1.push_valid = 1'b1;
        q1.pop_ready  = 1'b1;
        q1.Instruction_F = 32'h12345678; q1.NPC_F = 32'd7;
        #3;
        chk("byp_pop_valid", q1.pop_valid, 1);
        chk("byp_instr", q1.Instruction_D, 32'h12345678);
        chk("byp_npc", q1.NPC_D, 32'd7);
        chk("byp_count", count1, 0);
        @(posedge clk);
        #1;
        q1.push_valid = 1'b0;
        q1.pop_ready  = 1'b0;
        #3;
        chk("byp_after_count", count1, 0);
        chk("byp_after_pop_valid", q1.pop_valid, 0);
        chk("byp_after_instr", q1.Instruction_D, 32'h0);
        @(posedge clk);
        #1;

        // Bypass instance: decode stalled, entry stored
        q1.push_valid = 1'b1;
        #3;
        chk("byp_stall_view", {q1.pop_valid, q1.Instruction_D}, {1'b1, 32'h12345678});
        @(posedge clk);
        #1;
        q1.push_valid = 1'b0;
        #3;
        chk("byp_stored_count", count1, 1);
        chk("byp_stored_head", {q1.Instruction_D, q1.NPC_D}, {32'h12345678, 32'd7});
        @(posedge clk);
        #1;
        q1.pop_ready = 1'b1;
        @(posedge clk);
        #1;
        q1.pop_ready = 1'b0;
        #3;
        chk("byp_drained", count1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
